// File: rtl/sha_pio_pkg.sv
// Shared constants, op codes and FSM states for the Nios SHA PIO mailbox responder.
package sha_pio_pkg;

    localparam int MSG_WORDS = 16;
    localparam int DIG_WORDS = 8;
    localparam int CNT_W     = 8;
    localparam int MSG_IW    = $clog2(MSG_WORDS);
    localparam int DIG_IW    = $clog2(DIG_WORDS);

    localparam int ADDR_REQ    = 31;
    localparam int ADDR_OP_LSB = 28;

    localparam int ST_ACK   = 31;
    localparam int ST_BUSY  = 30;
    localparam int ST_VALID = 29;
    localparam int ST_ERR   = 28;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_WR_MSG = 3'd1,
        OP_RD_DIG = 3'd2,
        OP_START  = 3'd3,
        OP_CLEAR  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2
    } state_e;

endpackage

// File: rtl/sha_pio_responder.sv
// Toggle-handshake PIO command decoder with message buffer and digest store; drives an external SHA-256 core.
// Every request is acked one cycle after it is seen; busy persists from START until the core returns its digest.
module sha_pio_responder
    import sha_pio_pkg::*;
(
    input  logic         clk_clk,
    input  logic         reset_reset_n,
    input  logic [31:0]  sha_dout,
    input  logic [31:0]  sha_addr,
    output logic [31:0]  sha_din,
    output logic [31:0]  sha_status,
    output logic         core_start,
    output logic         core_init,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic         core_done,
    input  logic [255:0] core_digest
);

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       din_q, din_d;
    logic              start_q, start_d;
    logic              init_q, init_d;
    logic [31:0]       buf_q [MSG_WORDS];
    logic [31:0]       dig_q [DIG_WORDS];

    logic       req, busy, wr_en, clr_en, start_en, done_en;
    logic [2:0] op;
    logic [7:0] idx;
    logic       unused_addr;

    assign req         = sha_addr[ADDR_REQ] != ack_q;
    assign op          = sha_addr[ADDR_OP_LSB +: 3];
    assign idx         = sha_addr[7:0];
    assign busy        = state_q != S_IDLE;
    assign unused_addr = ^sha_addr[27:8];

    // Command decode: an errored command changes nothing but ack and the error flag.
    always_comb begin
        ack_d    = ack_q;
        err_d    = err_q;
        din_d    = din_q;
        wr_en    = 1'b0;
        clr_en   = 1'b0;
        start_en = 1'b0;
        if (req) begin
            ack_d = sha_addr[ADDR_REQ];
            err_d = 1'b0;
            case (op)
                OP_NOP: ;
                OP_WR_MSG: begin
                    if (busy || idx >= 8'(MSG_WORDS)) err_d = 1'b1;
                    else                              wr_en = 1'b1;
                end
                OP_RD_DIG: begin
                    if (!valid_q || idx >= 8'(DIG_WORDS)) err_d = 1'b1;
                    else                                  din_d = dig_q[idx[DIG_IW-1:0]];
                end
                OP_START: begin
                    if (busy) err_d    = 1'b1;
                    else      start_en = 1'b1;
                end
                OP_CLEAR: begin
                    if (busy) err_d  = 1'b1;
                    else      clr_en = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Core sequencing; a core_done outside RUN is ignored.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        done_en = 1'b0;
        case (state_q)
            S_IDLE:   if (start_en) state_d = S_LAUNCH;
            S_LAUNCH: if (core_ready) begin
                start_d = 1'b1;
                state_d = S_RUN;
            end
            S_RUN:    if (core_done) begin
                done_en = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        if (start_en) begin
            valid_d = 1'b0;
            init_d  = sha_dout[0];
        end
        if (clr_en) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end
        if (done_en) begin
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            din_q   <= '0;
            start_q <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            start_q <= start_d;
            init_q  <= init_d;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < MSG_WORDS; i++) buf_q[i] <= '0;
        end else if (clr_en) begin
            for (int i = 0; i < MSG_WORDS; i++) buf_q[i] <= '0;
        end else if (wr_en) begin
            buf_q[idx[MSG_IW-1:0]] <= sha_dout;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < DIG_WORDS; i++) dig_q[i] <= '0;
        end else if (done_en) begin
            for (int i = 0; i < DIG_WORDS; i++) dig_q[i] <= core_digest[255-32*i -: 32];
        end
    end

    always_comb begin
        core_block = '0;
        for (int i = 0; i < MSG_WORDS; i++) core_block[511-32*i -: 32] = buf_q[i];
    end

    assign sha_din    = din_q;
    assign sha_status = {ack_q, busy, valid_q, err_q, {(28-CNT_W){1'b0}}, cnt_q};
    assign core_start = start_q;
    assign core_init  = init_q;

endmodule

// File: tb/tb_sha_pio_responder.sv
// Directed bench for sha_pio_responder: commands, core launch/done, error rules, count wrap and reset.
module tb_sha_pio_responder;
    import sha_pio_pkg::*;

    logic         clk_clk = 1'b0;
    logic         reset_reset_n;
    logic [31:0]  sha_dout;
    logic [31:0]  sha_addr;
    logic [31:0]  sha_din;
    logic [31:0]  sha_status;
    logic         core_start;
    logic         core_init;
    logic [511:0] core_block;
    logic         core_ready;
    logic         core_done;
    logic [255:0] core_digest;

    int   total = 0;
    int   bad   = 0;
    logic req_tog = 1'b0;
    logic [7:0] exp_cnt;

    sha_pio_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .sha_dout      (sha_dout),
        .sha_addr      (sha_addr),
        .sha_din       (sha_din),
        .sha_status    (sha_status),
        .core_start    (core_start),
        .core_init     (core_init),
        .core_block    (core_block),
        .core_ready    (core_ready),
        .core_done     (core_done),
        .core_digest   (core_digest)
    );

    initial forever #5 clk_clk = ~clk_clk;

    // Toggle the request, present op/index/data, and return 1ns after the acking edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] idx, input logic [31:0] dat);
        req_tog  = ~req_tog;
        sha_addr = {req_tog, op, 20'h0, idx};
        sha_dout = dat;
        @(posedge clk_clk); #1;
    endtask

    task automatic set_digest(input int blk);
        for (int i = 0; i < 8; i++)
            core_digest[255-32*i -: 32] = 32'hC0DE0000 | 32'(blk << 4) | 32'(i);
    endtask

    task automatic wait_start(output logic seen);
        seen = core_start;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk_clk); #1;
            seen = core_start;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL start_timeout: core_start never seen"); end
    endtask

    task automatic run_block(input logic init, input int delay, input int blk);
        logic seen;
        issue(OP_START, 8'd0, {31'b0, init});
        total++;
        if (sha_status[31:28] !== {req_tog, 3'b100}) begin
            bad++; $display("FAIL start_ack: got %b want %b", sha_status[31:28], {req_tog, 3'b100});
        end
        wait_start(seen);
        total++;
        if (core_init !== init) begin bad++; $display("FAIL core_init: got %b want %b", core_init, init); end
        @(posedge clk_clk); #1;
        total++;
        if (core_start !== 1'b0) begin bad++; $display("FAIL start_width: core_start still %b", core_start); end
        repeat (delay) @(posedge clk_clk);
        #1;
        set_digest(blk);
        core_done = 1'b1;
        @(posedge clk_clk); #1;
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        sha_addr = '0; sha_dout = '0; core_ready = 1'b1; core_done = 1'b0; core_digest = '0;
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        total++;
        if (sha_status !== 32'h0) begin bad++; $display("FAIL rst_status: got %h want 0", sha_status); end
        total++;
        if (sha_din !== 32'h0) begin bad++; $display("FAIL rst_din: got %h want 0", sha_din); end
        total++;
        if ({core_start, core_init} !== 2'b00) begin bad++; $display("FAIL rst_core: got %b want 00", {core_start, core_init}); end
        total++;
        if (core_block !== 512'h0) begin bad++; $display("FAIL rst_block: got nonzero want 0"); end
        issue(OP_RD_DIG, 8'd0, 32'h0);
        total++;
        if ({sha_status[31], sha_status[28]} !== {req_tog, 1'b1} || sha_din !== 32'h0) begin
            bad++; $display("FAIL rd_before_start: ack/err=%b din=%h want %b din=0", {sha_status[31], sha_status[28]}, sha_din, {req_tog, 1'b1});
        end
        issue(OP_NOP, 8'd0, 32'h0);
        total++;
        if (sha_status[28] !== 1'b0) begin bad++; $display("FAIL nop_clears_err: got %b want 0", sha_status[28]); end
    endtask

    task automatic test_write_start();
        for (int i = 0; i < 16; i++) begin
            issue(OP_WR_MSG, 8'(i), 32'hA5A50000 + 32'(i));
            total++;
            if ({sha_status[31], sha_status[28]} !== {req_tog, 1'b0}) begin
                bad++; $display("FAIL wr_ack[%0d]: got %b want %b", i, {sha_status[31], sha_status[28]}, {req_tog, 1'b0});
            end
        end
        total++;
        if (core_block[511:480] !== 32'hA5A50000) begin bad++; $display("FAIL block_w0: got %h want A5A50000", core_block[511:480]); end
        total++;
        if (core_block[31:0] !== 32'hA5A5000F) begin bad++; $display("FAIL block_w15: got %h want A5A5000F", core_block[31:0]); end
        run_block(1'b1, 64, 1);
        total++;
        if (sha_status !== {req_tog, 3'b010, 20'h0, 8'd1}) begin
            bad++; $display("FAIL done_status: got %h want %h", sha_status, {req_tog, 3'b010, 20'h0, 8'd1});
        end
    endtask

    task automatic test_read();
        issue(OP_RD_DIG, 8'd3, 32'h0);
        total++;
        if (sha_din !== 32'hC0DE0013) begin bad++; $display("FAIL rd_idx3: got %h want C0DE0013", sha_din); end
        total++;
        if ({sha_status[31], sha_status[28]} !== {req_tog, 1'b0}) begin
            bad++; $display("FAIL rd_ack: got %b want %b", {sha_status[31], sha_status[28]}, {req_tog, 1'b0});
        end
        issue(OP_RD_DIG, 8'd0, 32'h0);
        total++;
        if (sha_din !== 32'hC0DE0010) begin bad++; $display("FAIL rd_idx0: got %h want C0DE0010", sha_din); end
        issue(OP_RD_DIG, 8'd7, 32'h0);
        total++;
        if (sha_din !== 32'hC0DE0017) begin bad++; $display("FAIL rd_idx7: got %h want C0DE0017", sha_din); end
    endtask

    task automatic test_errors();
        issue(OP_WR_MSG, 8'd16, 32'hFFFFFFFF);
        total++;
        if (sha_status[28] !== 1'b1 || core_block[511:480] !== 32'hA5A50000 || core_block[31:0] !== 32'hA5A5000F) begin
            bad++; $display("FAIL wr_idx16: err=%b w0=%h w15=%h want 1 A5A50000 A5A5000F", sha_status[28], core_block[511:480], core_block[31:0]);
        end
        for (int o = 5; o < 8; o++) begin
            issue(3'(o), 8'd0, 32'h0);
            total++;
            if ({sha_status[31], sha_status[28]} !== {req_tog, 1'b1} || sha_din !== 32'hC0DE0017) begin
                bad++; $display("FAIL illegal_op%0d: ack/err=%b din=%h want %b din=C0DE0017", o, {sha_status[31], sha_status[28]}, sha_din, {req_tog, 1'b1});
            end
        end
        issue(OP_RD_DIG, 8'd8, 32'h0);
        total++;
        if (sha_status[28] !== 1'b1 || sha_din !== 32'hC0DE0017) begin
            bad++; $display("FAIL rd_idx8: err=%b din=%h want 1 C0DE0017", sha_status[28], sha_din);
        end
    endtask

    task automatic test_busy_collision();
        logic seen;
        issue(OP_START, 8'd0, 32'h0);
        wait_start(seen);
        total++;
        if (core_init !== 1'b0) begin bad++; $display("FAIL chain_init: got %b want 0", core_init); end
        issue(OP_WR_MSG, 8'd0, 32'h11111111);
        total++;
        if (sha_status[28] !== 1'b1 || core_block[511:480] !== 32'hA5A50000) begin
            bad++; $display("FAIL wr_busy: err=%b w0=%h want 1 A5A50000", sha_status[28], core_block[511:480]);
        end
        issue(OP_START, 8'd0, 32'h1);
        total++;
        if (sha_status[31:28] !== {req_tog, 3'b101}) begin
            bad++; $display("FAIL start_busy: got %b want %b", sha_status[31:28], {req_tog, 3'b101});
        end
        issue(OP_RD_DIG, 8'd0, 32'h0);
        total++;
        if (sha_status[28] !== 1'b1 || sha_din !== 32'hC0DE0017) begin
            bad++; $display("FAIL rd_busy_invalid: err=%b din=%h want 1 C0DE0017", sha_status[28], sha_din);
        end
        issue(OP_NOP, 8'd0, 32'h0);
        total++;
        if (sha_status[31:28] !== {req_tog, 3'b100}) begin
            bad++; $display("FAIL nop_busy: got %b want %b", sha_status[31:28], {req_tog, 3'b100});
        end
        set_digest(2);
        core_done = 1'b1;
        issue(OP_WR_MSG, 8'd1, 32'h22222222);
        core_done = 1'b0;
        total++;
        if (sha_status !== {req_tog, 3'b011, 20'h0, 8'd2}) begin
            bad++; $display("FAIL wr_at_done_status: got %h want %h", sha_status, {req_tog, 3'b011, 20'h0, 8'd2});
        end
        total++;
        if (core_block[479:448] !== 32'hA5A50001) begin bad++; $display("FAIL wr_at_done_buf: got %h want A5A50001", core_block[479:448]); end
        issue(OP_WR_MSG, 8'd1, 32'h22222222);
        total++;
        if (sha_status[28] !== 1'b0 || core_block[479:448] !== 32'h22222222) begin
            bad++; $display("FAIL wr_after_done: err=%b w1=%h want 0 22222222", sha_status[28], core_block[479:448]);
        end
        issue(OP_RD_DIG, 8'd7, 32'h0);
        total++;
        if (sha_din !== 32'hC0DE0027) begin bad++; $display("FAIL rd_blk2: got %h want C0DE0027", sha_din); end
    endtask

    task automatic test_wrap();
        exp_cnt = 8'd2;
        for (int k = 0; k < 254; k++) begin
            run_block(1'b0, 2, k);
            exp_cnt = exp_cnt + 8'd1;
            total++;
            if (sha_status[7:0] !== exp_cnt) begin
                bad++; $display("FAIL count_step%0d: got %0d want %0d", k, sha_status[7:0], exp_cnt);
            end
            if (k == 252) begin
                total++;
                if (sha_status[7:0] !== 8'd255) begin bad++; $display("FAIL count_255: got %0d want 255", sha_status[7:0]); end
            end
        end
        total++;
        if (sha_status[7:0] !== 8'd0 || sha_status[29] !== 1'b1) begin
            bad++; $display("FAIL count_wrap: cnt=%0d valid=%b want 0 1", sha_status[7:0], sha_status[29]);
        end
    endtask

    task automatic test_clear();
        run_block(1'b0, 3, 5);
        total++;
        if (sha_status[7:0] !== 8'd1) begin bad++; $display("FAIL count_after_wrap: got %0d want 1", sha_status[7:0]); end
        issue(OP_CLEAR, 8'd0, 32'h0);
        total++;
        if (sha_status !== {req_tog, 31'h0}) begin bad++; $display("FAIL clear_status: got %h want %h", sha_status, {req_tog, 31'h0}); end
        total++;
        if (core_block !== 512'h0) begin bad++; $display("FAIL clear_block: w0=%h w1=%h want 0", core_block[511:480], core_block[479:448]); end
        total++;
        if (sha_din !== 32'hC0DE0027) begin bad++; $display("FAIL clear_din: got %h want C0DE0027", sha_din); end
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        issue(OP_WR_MSG, 8'd0, 32'hDEADBEEF);
        issue(OP_START, 8'd0, 32'h1);
        wait_start(seen);
        reset_reset_n = 1'b0;
        #1;
        total++;
        if (sha_status !== 32'h0 || sha_din !== 32'h0 || core_start !== 1'b0) begin
            bad++; $display("FAIL async_reset: status=%h din=%h start=%b want 0 0 0", sha_status, sha_din, core_start);
        end
        req_tog = 1'b0; sha_addr = '0; sha_dout = '0;
        @(posedge clk_clk); #1;
        total++;
        if (core_block !== 512'h0 || core_init !== 1'b0 || sha_status !== 32'h0) begin
            bad++; $display("FAIL reset_hold: w0=%h init=%b status=%h want 0", core_block[511:480], core_init, sha_status);
        end
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        issue(OP_RD_DIG, 8'd0, 32'h0);
        total++;
        if (sha_status[31:28] !== 4'b1001 || sha_din !== 32'h0) begin
            bad++; $display("FAIL post_reset_rd: st=%b din=%h want 1001 0", sha_status[31:28], sha_din);
        end
        issue(OP_START, 8'd0, 32'h1);
        total++;
        if (sha_status[31:28] !== 4'b0100) begin bad++; $display("FAIL post_reset_start: got %b want 0100", sha_status[31:28]); end
    endtask

    initial begin
        test_reset();
        test_write_start();
        test_read();
        test_errors();
        test_busy_collision();
        test_wrap();
        test_clear();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
